// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the iterative population counter.
package popcnt_pkg;

   typedef enum logic [1:0] {IDLE, COUNT, DONE} popcnt_state_t;

   // Number of CHUNK-wide passes needed for one operand.
   function automatic int unsigned num_chunks(input int unsigned width,
                                              input int unsigned chunk,
                                              input logic        word);
      if (word && (width == 64)) return 32 / chunk;
      return width / chunk;
   endfunction

endpackage

// File: rtl/popcnt_chunk.sv
// Combinational population count of one CHUNK-bit slice.
module popcnt_chunk #(
   parameter int unsigned CHUNK = 16
) (
   input  logic [CHUNK-1:0]       data_i,
   output logic [$clog2(CHUNK):0] count_o
);

   localparam int unsigned OW = $clog2(CHUNK) + 1;

   always_comb begin
      count_o = '0;
      for (int i = 0; i < CHUNK; i++) begin
         count_o = count_o + OW'(data_i[i]);
      end
   end

endmodule

// File: rtl/popcnt_iter.sv
// Iterative population count, CHUNK bits per cycle, with valid/ready on both sides.
// Optional WALLY_POPCNT_FLUSH_EN adds a Flush input that aborts any operation.
module popcnt_iter
   import popcnt_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CHUNK = 16
) (
   input  logic                     clk,
   input  logic                     reset,
`ifdef WALLY_POPCNT_FLUSH_EN
   input  logic                     Flush,
`endif
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [WIDTH-1:0]         A,
   input  logic                     W,
   output logic                     OutValid,
   input  logic                     OutReady,
   output logic [$clog2(WIDTH):0]   Count,
   output logic                     Busy
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned NW = $clog2(WIDTH);
   localparam int unsigned PW = $clog2(CHUNK) + 1;
   localparam logic [NW-1:0] LastFull = NW'(num_chunks(WIDTH, CHUNK, 1'b0) - 1);
   localparam logic [NW-1:0] LastWord = NW'(num_chunks(WIDTH, CHUNK, 1'b1) - 1);
   localparam bit WordOk = (WIDTH == 64);

   if ((WIDTH != 32) && (WIDTH != 64)) begin : g_bad_width
      $error("popcnt_iter: WIDTH must be 32 or 64");
   end
   if ((CHUNK == 0) || ((CHUNK & (CHUNK - 1)) != 0)) begin : g_bad_chunk_pow2
      $error("popcnt_iter: CHUNK must be a power of 2");
   end
   if ((CHUNK > 32) || ((32 % CHUNK) != 0)) begin : g_bad_chunk_div
      $error("popcnt_iter: CHUNK must divide 32");
   end

   popcnt_state_t      state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [NW-1:0]      cnt_q, cnt_d;
   logic [CW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      chunk_pop;
   logic [CW-1:0]      acc_sum;
   logic               flush;
   logic               accept;
   logic               word_mode;

`ifdef WALLY_POPCNT_FLUSH_EN
   assign flush = Flush;
`else
   assign flush = 1'b0;
`endif

   assign accept    = InValid & InReady;
   assign word_mode = WordOk & W;

   popcnt_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .data_i  (shift_q[CHUNK-1:0]),
      .count_o (chunk_pop)
   );

   assign acc_sum = acc_q + CW'(chunk_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = COUNT;
         COUNT:   if (cnt_q == '0) state_d = DONE;
         DONE: begin
            if (accept)        state_d = COUNT;
            else if (OutReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      count_d = count_q;
      if (accept) begin
         shift_d = word_mode ? WIDTH'(A[31:0]) : A;
         acc_d   = '0;
         cnt_d   = word_mode ? LastWord : LastFull;
      end else if ((state_q == COUNT) && !flush) begin
         shift_d = shift_q >> CHUNK;
         acc_d   = acc_sum;
         cnt_d   = cnt_q - NW'(1);
         // Result becomes visible only on the edge entering DONE.
         if (cnt_q == '0) count_d = acc_sum;
      end
   end

   always_comb begin
      InReady  = !flush && ((state_q == IDLE) || ((state_q == DONE) && OutReady));
      OutValid = (state_q == DONE);
      Busy     = (state_q != IDLE);
      Count    = count_q;
   end

endmodule

// File: tb/tb_popcnt_iter.sv
// Directed self-checking bench for popcnt_iter (WIDTH=64, CHUNK=16).
module tb_popcnt_iter;

   logic        clk = 1'b0;
   logic        reset;
   logic        InValid;
   logic        InReady;
   logic [63:0] A;
   logic        W;
   logic        OutValid;
   logic        OutReady;
   logic [6:0]  Count;
   logic        Busy;
`ifdef WALLY_POPCNT_FLUSH_EN
   logic        Flush = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   popcnt_iter #(
      .WIDTH (64),
      .CHUNK (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
`ifdef WALLY_POPCNT_FLUSH_EN
      .Flush    (Flush),
`endif
      .InValid  (InValid),
      .InReady  (InReady),
      .A        (A),
      .W        (W),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Count    (Count),
      .Busy     (Busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operand for a single accept edge, then drop InValid.
   task automatic issue(input logic [63:0] a, input logic w);
      A       = a;
      W       = w;
      InValid = 1'b1;
      step();
      InValid = 1'b0;
   endtask

   // Edges until OutValid, or -1 if it never rises within the budget.
   task automatic wait_valid(output int cyc);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         cyc++;
         if (OutValid) seen = 1'b1;
      end
      if (!seen) cyc = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1; InValid = 1'b0; A = '0; W = 1'b0; OutReady = 1'b1;
      #2;
      checks++;
      if (OutValid !== 1'b0 || Busy !== 1'b0 || Count !== 7'd0) begin
         errors++;
         $display("FAIL reset_state: OutValid=%b Busy=%b Count=%0d, required 0 0 0",
                  OutValid, Busy, Count);
      end
      step();
      reset = 1'b0;
      step();
      checks++;
      if (InReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_inready: got %b, required 1", InReady);
      end
   endtask

   task automatic test_zero_ones();
      int cyc;
      OutReady = 1'b1;
      issue(64'h0, 1'b0);
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || Count !== 7'd0) begin
         errors++;
         $display("FAIL zero_operand: latency=%0d Count=%0d, required 4 0", cyc, Count);
      end
      step();
      checks++;
      if (Busy !== 1'b0 || OutValid !== 1'b0) begin
         errors++;
         $display("FAIL retire_to_idle: Busy=%b OutValid=%b, required 0 0", Busy, OutValid);
      end
      issue({64{1'b1}}, 1'b0);
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || Count !== 7'd64) begin
         errors++;
         $display("FAIL all_ones: latency=%0d Count=%0d, required 4 64", cyc, Count);
      end
      step();
   endtask

   task automatic test_word_mode();
      int cyc;
      OutReady = 1'b1;
      issue(64'hFFFF_FFFF_0000_000F, 1'b1);
      wait_valid(cyc);
      checks++;
      if (cyc != 2 || Count !== 7'd4) begin
         errors++;
         $display("FAIL word_mode: latency=%0d Count=%0d, required 2 4", cyc, Count);
      end
      step();
      issue(64'hFFFF_FFFF_0000_000F, 1'b0);
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || Count !== 7'd36) begin
         errors++;
         $display("FAIL full_mode: latency=%0d Count=%0d, required 4 36", cyc, Count);
      end
      step();
   endtask

   task automatic test_hold();
      int cyc;
      OutReady = 1'b0;
      issue(64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || Count !== 7'd32) begin
         errors++;
         $display("FAIL hold_first: latency=%0d Count=%0d, required 4 32", cyc, Count);
      end
      // A competing operand must be ignored while the result is stalled.
      A = 64'h1; InValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (OutValid !== 1'b1 || Count !== 7'd32 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: OutValid=%b Count=%0d InReady=%b, required 1 32 0",
                     i, OutValid, Count, InReady);
         end
      end
      InValid = 1'b0; OutReady = 1'b1;
      step();
      checks++;
      if (OutValid !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: OutValid=%b Busy=%b, required 0 0", OutValid, Busy);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      OutReady = 1'b1;
      A = 64'h1; W = 1'b0; InValid = 1'b1;
      step();
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || Count !== 7'd1 || InReady !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: latency=%0d Count=%0d InReady=%b, required 4 1 1",
                  cyc, Count, InReady);
      end
      A = 64'h3;
      step();
      InValid = 1'b0;
      checks++;
      if (Busy !== 1'b1 || OutValid !== 1'b0 || Count !== 7'd1) begin
         errors++;
         $display("FAIL b2b_reload: Busy=%b OutValid=%b Count=%0d, required 1 0 1",
                  Busy, OutValid, Count);
      end
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || Count !== 7'd2) begin
         errors++;
         $display("FAIL b2b_second: latency=%0d Count=%0d, required 4 2", cyc, Count);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int cyc;
      OutReady = 1'b1;
      issue({64{1'b1}}, 1'b0);
      step();
      reset = 1'b1;
      #1;
      checks++;
      if (OutValid !== 1'b0 || Busy !== 1'b0 || Count !== 7'd0) begin
         errors++;
         $display("FAIL reset_mid: OutValid=%b Busy=%b Count=%0d, required 0 0 0",
                  OutValid, Busy, Count);
      end
      step();
      reset = 1'b0;
      step();
      issue(64'h7, 1'b0);
      wait_valid(cyc);
      checks++;
      if (cyc != 4 || Count !== 7'd3) begin
         errors++;
         $display("FAIL after_reset_op: latency=%0d Count=%0d, required 4 3", cyc, Count);
      end
      step();
   endtask

`ifdef WALLY_POPCNT_FLUSH_EN
   task automatic test_flush();
      bit valid_seen;
      OutReady = 1'b1;
      issue({64{1'b1}}, 1'b0);
      step();
      Flush = 1'b1;
      #1;
      checks++;
      if (InReady !== 1'b0) begin
         errors++;
         $display("FAIL flush_inready: got %b, required 0", InReady);
      end
      step();
      Flush = 1'b0;
      checks++;
      if (Busy !== 1'b0 || OutValid !== 1'b0) begin
         errors++;
         $display("FAIL flush_count: Busy=%b OutValid=%b, required 0 0", Busy, OutValid);
      end
      valid_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (OutValid) valid_seen = 1'b1;
      end
      checks++;
      if (valid_seen) begin
         errors++;
         $display("FAIL flush_no_result: OutValid seen=1, required 0");
      end
      Flush = 1'b1; A = 64'hF; InValid = 1'b1;
      #1;
      checks++;
      if (InReady !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle_inready: got %b, required 0", InReady);
      end
      step();
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle_accept: Busy=%b, required 0", Busy);
      end
      Flush = 1'b0; InValid = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_zero_ones();
      test_word_mode();
      test_hold();
      test_back_to_back();
      test_reset_mid();
`ifdef WALLY_POPCNT_FLUSH_EN
      test_flush();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
